// File: rtl/pulse_distributor_ctrl.sv
// Burst sequencer rotating a one-hot phase across q[3:0]; all outputs registered, first phase appears the cycle after start.
// No backpressure: start is ignored outside IDLE, stop aborts a running burst on the next edge.
module pulse_distributor_ctrl #(
    parameter int WIDTH_W = 8,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               dir,
    input  logic [WIDTH_W-1:0] phase_width,
    input  logic [COUNT_W-1:0] rounds,
    output logic [3:0]         q,
    output logic [1:0]         phase_idx,
    output logic [COUNT_W-1:0] round_cnt,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic               dir_q, dir_d;
    logic [WIDTH_W-1:0] width_q, width_d;
    logic [COUNT_W-1:0] rounds_q, rounds_d;
    logic [WIDTH_W-1:0] ph_cnt_q, ph_cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic [3:0]         q_q, q_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               launch;
    logic               phase_end;
    logic               last_phase;
    logic [COUNT_W-1:0] cnt_inc;
    logic               burst_end;

    assign launch     = start && !stop;
    assign phase_end  = (ph_cnt_q == width_q);
    assign last_phase = dir_q ? (idx_q == 2'd0) : (idx_q == 2'd3);
    assign cnt_inc    = cnt_q + 1'b1;
    // rounds of zero means run until stopped, so it never ends a burst
    assign burst_end  = phase_end && last_phase && (rounds_q != '0) && (cnt_inc == rounds_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            dir_q    <= 1'b0;
            width_q  <= '0;
            rounds_q <= '0;
            ph_cnt_q <= '0;
            idx_q    <= 2'd0;
            q_q      <= 4'b0000;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            width_q  <= width_d;
            rounds_q <= rounds_d;
            ph_cnt_q <= ph_cnt_d;
            idx_q    <= idx_d;
            q_q      <= q_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (launch) state_d = S_RUN;
            S_RUN: begin
                if (stop)           state_d = S_IDLE;
                else if (burst_end) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        dir_d    = dir_q;
        width_d  = width_q;
        rounds_d = rounds_q;
        ph_cnt_d = ph_cnt_q;
        idx_d    = idx_q;
        q_d      = q_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    dir_d    = dir;
                    width_d  = (phase_width == '0) ? WIDTH_W'(1) : phase_width;
                    rounds_d = rounds;
                    cnt_d    = '0;
                    ph_cnt_d = WIDTH_W'(1);
                    idx_d    = dir ? 2'd3 : 2'd0;
                    q_d      = dir ? 4'b1000 : 4'b0001;
                    busy_d   = 1'b1;
                end
            end
            S_RUN: begin
                if (stop) begin
                    q_d    = 4'b0000;
                    idx_d  = 2'd0;
                    busy_d = 1'b0;
                end else if (phase_end) begin
                    ph_cnt_d = WIDTH_W'(1);
                    if (last_phase) cnt_d = cnt_inc;
                    if (burst_end) begin
                        q_d    = 4'b0000;
                        idx_d  = 2'd0;
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        idx_d = dir_q ? (idx_q - 2'd1) : (idx_q + 2'd1);
                        q_d   = 4'b0001 << idx_d;
                    end
                end else begin
                    ph_cnt_d = ph_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign q         = q_q;
    assign phase_idx = idx_q;
    assign round_cnt = cnt_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pulse_distributor_ctrl.sv
// Directed bench: cycle-accurate arithmetic model of the burst sequencer plus literal expectations.
module tb_pulse_distributor_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0, stop = 1'b0, dir = 1'b0;
    logic [7:0] phase_width = 8'd0, rounds = 8'd0;
    logic [3:0] q;
    logic [1:0] phase_idx;
    logic [7:0] round_cnt;
    logic       busy, done;

    logic       start2 = 1'b0, stop2 = 1'b0, dir2 = 1'b0;
    logic [7:0] phase_width2 = 8'd1;
    logic [1:0] rounds2 = 2'd0;
    logic [3:0] q2;
    logic [1:0] phase_idx2;
    logic [1:0] round_cnt2;
    logic       busy2, done2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pulse_distributor_ctrl #(.WIDTH_W(8), .COUNT_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .dir(dir),
        .phase_width(phase_width), .rounds(rounds),
        .q(q), .phase_idx(phase_idx), .round_cnt(round_cnt), .busy(busy), .done(done)
    );

    pulse_distributor_ctrl #(.WIDTH_W(8), .COUNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .stop(stop2), .dir(dir2),
        .phase_width(phase_width2), .rounds(rounds2),
        .q(q2), .phase_idx(phase_idx2), .round_cnt(round_cnt2), .busy(busy2), .done(done2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: m_k counts RUN cycles since launch; outputs follow from k, width and direction.
    int m_st = 0;   // 0 idle, 1 run, 2 done
    int m_k = 0, m_w = 1, m_r = 0, m_hold = 0;
    bit m_dir = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_st = 0; m_k = 0; m_w = 1; m_r = 0; m_hold = 0; m_dir = 1'b0;
        end else begin
            case (m_st)
                0: if (start && !stop) begin
                    m_st = 1; m_k = 1; m_dir = dir; m_r = rounds; m_hold = 0;
                    m_w = (phase_width == 0) ? 1 : phase_width;
                end
                1: if (stop) begin
                    m_hold = ((m_k - 1) / (4 * m_w)) % 256;
                    m_st = 0;
                end else begin
                    m_k++;
                    if (m_r != 0 && m_k > 4 * m_r * m_w) begin
                        m_st = 2; m_hold = m_r;
                    end
                end
                default: m_st = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        int eq, eidx, ecnt, ebusy, edone, ph, pos;
        eq = 0; eidx = 0; ecnt = m_hold; ebusy = 0; edone = 0;
        if (m_st == 1) begin
            ph    = (m_k - 1) / m_w;
            pos   = m_dir ? 3 - (ph % 4) : ph % 4;
            eq    = 1 << pos;
            eidx  = pos;
            ecnt  = (ph / 4) % 256;
            ebusy = 1;
        end else if (m_st == 2) begin
            edone = 1;
        end
        chk("model_q", q, eq);
        chk("model_phase_idx", phase_idx, eidx);
        chk("model_round_cnt", round_cnt, ecnt);
        chk("model_busy", busy, ebusy);
        chk("model_done", done, edone);
    end

    // Returns at the negedge inside RUN cycle 1; afterwards scrambles the config inputs.
    task automatic start_burst(input bit d, input int w, input int r);
        @(negedge clk);
        dir = d; phase_width = 8'(w); rounds = 8'(r); start = 1'b1;
        @(negedge clk);
        start = 1'b0; dir = ~d; phase_width = 8'd7; rounds = 8'd3;
    endtask

    initial begin
        logic [3:0] seq2 [8];
        logic [3:0] seq3 [4];
        logic [1:0] wrap_tab [5];
        seq2 = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd4, 4'd4, 4'd8, 4'd8};
        seq3 = '{4'd8, 4'd4, 4'd2, 4'd1};
        wrap_tab = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        @(negedge clk);
        chk("reset_q", q, 0);
        chk("reset_busy", busy, 0);
        chk("reset_round_cnt", round_cnt, 0);
        reset = 1'b0;

        // Reset landing mid-burst clears outputs without waiting for a clock edge
        start_burst(1'b0, 3, 0);
        repeat (14) @(negedge clk);
        chk("pre_reset_round_cnt", round_cnt, 1);
        chk("pre_reset_busy", busy, 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_q", q, 0);
        chk("async_reset_busy", busy, 0);
        chk("async_reset_round_cnt", round_cnt, 0);
        @(negedge clk);
        reset = 1'b0;

        // Forward, width 2, two rounds
        start_burst(1'b0, 2, 2);
        for (int c = 1; c <= 16; c++) begin
            chk("fwd_q", q, seq2[(c - 1) % 8]);
            chk("fwd_busy", busy, 1);
            @(negedge clk);
        end
        chk("fwd_done_c17", done, 1);
        chk("fwd_round_cnt", round_cnt, 2);
        chk("fwd_q_c17", q, 0);
        @(negedge clk);
        chk("fwd_done_drop", done, 0);
        chk("fwd_idle_busy", busy, 0);

        // Backward, width 0 forced to 1, one round
        start_burst(1'b1, 0, 1);
        for (int c = 1; c <= 4; c++) begin
            chk("bwd_q", q, seq3[c - 1]);
            @(negedge clk);
        end
        chk("bwd_done_c5", done, 1);
        chk("bwd_round_cnt", round_cnt, 1);

        // Stop during a continuous burst
        start_burst(1'b0, 4, 0);
        repeat (9) @(negedge clk);
        chk("stop_q_c10", q, 4'b0100);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_q", q, 0);
        chk("stop_busy", busy, 0);
        chk("stop_done", done, 0);
        chk("stop_round_cnt", round_cnt, 0);

        // start with stop in IDLE, then start repeated during RUN and DONE
        @(negedge clk);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("startstop_busy", busy, 0);
        chk("startstop_q", q, 0);
        start_burst(1'b0, 1, 1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rerun_q_c3", q, 4'b0100);
        @(negedge clk);
        chk("rerun_q_c4", q, 4'b1000);
        @(negedge clk);
        chk("rerun_done_c5", done, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("redone_busy", busy, 0);
        chk("redone_done", done, 0);
        @(negedge clk);
        chk("redone_busy2", busy, 0);

        // Narrow round counter wraps in a continuous burst
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            chk("wrap_q", q2, 1 << ((c - 1) % 4));
            chk("wrap_onehot", $onehot(q2), 1);
            chk("wrap_round_cnt", round_cnt2, ((c - 1) / 4) % 4);
            if ((c - 1) % 4 == 0) chk("wrap_tab", round_cnt2, wrap_tab[(c - 1) / 4]);
            @(negedge clk);
        end
        stop2 = 1'b1;
        @(negedge clk);
        stop2 = 1'b0;
        chk("wrap_stop_busy", busy2, 0);
        chk("wrap_stop_q", q2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
